reveal_ctrl: RTL and testbench
==============================

Name: reveal_ctrl

Overview:
- Tile-reveal sequencer for the 8x8 minesweeper board.
- On a player click it reveals the selected tile. If the tile has zero adjacent mines, it flood-fills outward through zero-count neighbours using a pending bitmap.
- Consumes the per-tile 4-bit adjacency vector and its done flag from the adjacency-count FSM, plus the mine and flag maps.
- Produces the revealed map, game-over (mine hit) and win status for the display/game-top logic.

Parameters:
- None. Grid is fixed at 8x8 to match the 64-bit mine_map and 256-bit adj.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- new_game  input  1  sync clear of revealed/pending/status; honoured only in IDLE
- start  input  1  click request, sampled in IDLE only
- sel_index  input  6  clicked tile; row = [5:3], col = [2:0]
- adj_valid  input  1  adjacency map complete (done from the adjacency FSM)
- mine_map  input  64  bit i = mine at tile i
- flag_map  input  64  bit i = player flag on tile i
- adj  input  256  count of tile i at adj[4i+3:4i]
- revealed  output  64  bit i = tile i revealed
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at end of an accepted click
- hit_mine  output  1  sticky: a mine was revealed
- win  output  1  sticky: all non-mine tiles revealed, no mine hit

Behaviour:
- Reset (rst=1 at edge): state=IDLE; revealed, pending, done, hit_mine and win all 0. Reset overrides everything, including mid-flood.
- new_game in IDLE: clears revealed, pending, hit_mine and win. It takes priority over a same-cycle start, and that start is dropped.
- Upstream holds mine_map, flag_map and adj stable while busy=1.
- States:
  - IDLE, POP, SCAN, FINISH.
  - 3-bit neighbour counter k.
  - 64-bit pending bitmap.
- IDLE, accept rule: start=1, adj_valid=1, hit_mine=0, win=0, revealed[sel]=0 and flag_map[sel]=0.
  - Otherwise start is ignored: no state change and no done pulse.
- IDLE, on accept:
  - If mine_map[sel]=1: set revealed[sel] and hit_mine; go to FINISH.
  - Else: set pending[sel]; go to POP.
- POP:
  - If pending==0: go to FINISH.
  - Else take p = lowest-index set bit. Clear pending[p] and set revealed[p].
  - If adj count of p is 0: k=0, go to SCAN. Else stay in POP.
- SCAN, one neighbour per cycle, k = 0..7 in order NW, N, NE, W, E, SW, S, SE, i.e. (dr,dc) = (-1,-1), (-1,0), (-1,+1), (0,-1), (0,+1), (+1,-1), (+1,0), (+1,+1).
  - Row/col arithmetic uses 4-bit signed values. Out-of-range neighbours (row or col <0 or >7) are skipped; there is no wrap-around.
  - In-range neighbour n gets pending[n] set if revealed[n]=0, flag_map[n]=0 and mine_map[n]=0.
  - After k=7: go to POP.
- FINISH: done=1 for this one cycle.
  - win is set if hit_mine=0 and (revealed | mine_map) == all ones.
  - Next state is IDLE.
- Latency:
  - Mine click: done in cycle 1 after the accept cycle.
  - Nonzero safe tile: done in cycle 3 after the start cycle (POP, POP, FINISH).
  - Worst case, a full flood: at most 64*9+2 = 578 cycles.
- Flags block flood propagation. Flagged tiles are never revealed by this block.
- A neighbour that is already pending is not re-added; the OR into pending is idempotent. Each tile is popped at most once.

Test Plan:
1. Mines at tiles 0 and 63, adj correct; click sel=9 (adj=1) -> done 3 cycles after start; revealed = 64'h200; hit_mine=0, win=0.
2. Click sel=0 on the same board -> done 1 cycle after start; revealed[0]=1; hit_mine=1. A later start on sel=5 gives no busy and no done.
3. Empty mine_map, all adj=0; click sel=27 -> revealed = all ones; win=1; done within 578 cycles; busy high throughout.
4. Empty board with flag_map column 4 all set; click sel=0 -> revealed covers cols 0-3 only (64'h0F0F0F0F0F0F0F0F); win=0.
5. start with adj_valid=0, or on an already revealed or flagged tile -> ignored, busy stays 0. new_game and start together -> state cleared, start dropped.
6. Assert rst mid-flood in scenario 3 -> next cycle revealed=0, busy=0, done=0. Then a click on sel=9 in the scenario 1 board completes normally.

Source files
------------

// File: rtl/reveal_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reveal_ctrl
//  Description : Tile-reveal sequencer for the 8x8 minesweeper board.
//                Reveals the clicked tile and flood-fills through
//                zero-count neighbours using a pending bitmap.
//  Revision    : 1.0  initial release
// ============================================================================
module reveal_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         new_game,
   input  logic         start,
   input  logic [5:0]   sel_index,
   input  logic         adj_valid,
   input  logic [63:0]  mine_map,
   input  logic [63:0]  flag_map,
   input  logic [255:0] adj,
   output logic [63:0]  revealed,
   output logic         busy,
   output logic         done,
   output logic         hit_mine,
   output logic         win
);

   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_pop    = 2'd1;
   localparam logic [1:0] c_st_scan   = 2'd2;
   localparam logic [1:0] c_st_finish = 2'd3;

   logic [1:0]  r_state;
   logic [63:0] r_pending;
   logic [63:0] r_revealed;
   logic [2:0]  r_k;
   logic [5:0]  r_p;
   logic        r_hit;
   logic        r_win;

   logic              w_accept;
   logic [5:0]        w_pop_idx;
   logic [3:0]        w_pop_cnt;
   logic signed [3:0] w_dr;
   logic signed [3:0] w_dc;
   logic signed [3:0] w_nr;
   logic signed [3:0] w_nc;
   logic              w_nb_in;
   logic [5:0]        w_nb_idx;
   logic              w_nb_add;

   // A click is taken only on a live game, a ready adjacency map and a
   // tile that is neither revealed nor flagged; new_game wins over start.
   assign w_accept = (r_state == c_st_idle) && !new_game && start && adj_valid &&
                     !r_hit && !r_win && !r_revealed[sel_index] && !flag_map[sel_index];

   // Lowest-index set bit of the pending bitmap (scan downwards so the
   // last assignment is the lowest index).
   always_comb begin
      w_pop_idx = 6'd0;
      for (int i = 63; i >= 0; i--) begin
         if (r_pending[i]) w_pop_idx = i[5:0];
      end
   end

   assign w_pop_cnt = adj[{w_pop_idx, 2'b00} +: 4];

   // Neighbour k of the tile being scanned; a 4-bit signed coordinate is in
   // range exactly when its sign/overflow bit is clear (values -1..8).
   always_comb begin
      w_dr = 4'sd0;
      w_dc = 4'sd0;
      case (r_k)
         3'd0: begin w_dr = -4'sd1; w_dc = -4'sd1; end
         3'd1: begin w_dr = -4'sd1; w_dc =  4'sd0; end
         3'd2: begin w_dr = -4'sd1; w_dc =  4'sd1; end
         3'd3: begin w_dr =  4'sd0; w_dc = -4'sd1; end
         3'd4: begin w_dr =  4'sd0; w_dc =  4'sd1; end
         3'd5: begin w_dr =  4'sd1; w_dc = -4'sd1; end
         3'd6: begin w_dr =  4'sd1; w_dc =  4'sd0; end
         default: begin w_dr = 4'sd1; w_dc = 4'sd1; end
      endcase
      w_nr     = $signed({1'b0, r_p[5:3]}) + w_dr;
      w_nc     = $signed({1'b0, r_p[2:0]}) + w_dc;
      w_nb_in  = !w_nr[3] && !w_nc[3];
      w_nb_idx = {w_nr[2:0], w_nc[2:0]};
      w_nb_add = w_nb_in && !r_revealed[w_nb_idx] &&
                 !flag_map[w_nb_idx] && !mine_map[w_nb_idx];
   end

   // Sequencer: click acceptance, pop/scan flood fill and status update.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= c_st_idle;
         r_pending  <= 64'd0;
         r_revealed <= 64'd0;
         r_k        <= 3'd0;
         r_p        <= 6'd0;
         r_hit      <= 1'b0;
         r_win      <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (new_game) begin
                  r_pending  <= 64'd0;
                  r_revealed <= 64'd0;
                  r_hit      <= 1'b0;
                  r_win      <= 1'b0;
               end else if (w_accept) begin
                  if (mine_map[sel_index]) begin
                     r_revealed[sel_index] <= 1'b1;
                     r_hit                 <= 1'b1;
                     r_state               <= c_st_finish;
                  end else begin
                     r_pending[sel_index] <= 1'b1;
                     r_state              <= c_st_pop;
                  end
               end
            end
            c_st_pop: begin
               if (r_pending == 64'd0) begin
                  r_state <= c_st_finish;
               end else begin
                  r_pending[w_pop_idx]  <= 1'b0;
                  r_revealed[w_pop_idx] <= 1'b1;
                  r_p                   <= w_pop_idx;
                  if (w_pop_cnt == 4'd0) begin
                     r_k     <= 3'd0;
                     r_state <= c_st_scan;
                  end
               end
            end
            c_st_scan: begin
               if (w_nb_add) r_pending[w_nb_idx] <= 1'b1;
               r_k <= r_k + 3'd1;
               if (r_k == 3'd7) r_state <= c_st_pop;
            end
            c_st_finish: begin
               if (!r_hit && ((r_revealed | mine_map) == {64{1'b1}})) r_win <= 1'b1;
               r_state <= c_st_idle;
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   assign revealed = r_revealed;
   assign busy     = (r_state != c_st_idle);
   assign done     = (r_state == c_st_finish);
   assign hit_mine = r_hit;
   assign win      = r_win;

endmodule
`default_nettype wire

// File: tb/tb_reveal_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reveal_ctrl
//  Description : Directed self-checking bench for reveal_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reveal_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         new_game;
   logic         start;
   logic [5:0]   sel_index;
   logic         adj_valid;
   logic [63:0]  mine_map;
   logic [63:0]  flag_map;
   logic [255:0] adj;
   logic [63:0]  revealed;
   logic         busy;
   logic         done;
   logic         hit_mine;
   logic         win;

   int n_vec = 0;
   int n_err = 0;

   reveal_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .new_game  (new_game),
      .start     (start),
      .sel_index (sel_index),
      .adj_valid (adj_valid),
      .mine_map  (mine_map),
      .flag_map  (flag_map),
      .adj       (adj),
      .revealed  (revealed),
      .busy      (busy),
      .done      (done),
      .hit_mine  (hit_mine),
      .win       (win)
   );

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference adjacency counts for a given mine map.
   function automatic logic [255:0] adj_of(input logic [63:0] m);
      logic [255:0] a;
      logic [3:0]   cnt;
      a = '0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            cnt = 4'd0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if ((dr != 0 || dc != 0) && (r + dr >= 0) && (r + dr < 8) &&
                      (c + dc >= 0) && (c + dc < 8) && m[(r + dr) * 8 + (c + dc)])
                     cnt = cnt + 4'd1;
               end
            end
            a[(r * 8 + c) * 4 +: 4] = cnt;
         end
      end
      return a;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a click and count cycles until done (cycle 1 = first after start).
   task automatic click(input logic [5:0] s, output int lat, output logic busy_ok);
      sel_index = s;
      start     = 1'b1;
      tick();
      start   = 1'b0;
      lat     = 1;
      busy_ok = 1'b1;
      while (!done && lat < 700) begin
         if (!busy) busy_ok = 1'b0;
         tick();
         lat++;
      end
      if (!busy) busy_ok = 1'b0;
   endtask

   task automatic try_ignored(input string tag, input logic [5:0] s);
      sel_index = s;
      start     = 1'b1;
      tick();
      start = 1'b0;
      check_vec({tag, "_busy0"}, {63'd0, busy}, 64'd0);
      check_vec({tag, "_done0"}, {63'd0, done}, 64'd0);
      tick();
      check_vec({tag, "_busy1"}, {63'd0, busy}, 64'd0);
   endtask

   task automatic clear_game();
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
   endtask

   int   lat;
   logic bok;

   initial begin
      rst       = 1'b1;
      new_game  = 1'b0;
      start     = 1'b0;
      sel_index = 6'd0;
      adj_valid = 1'b1;
      mine_map  = 64'h8000_0000_0000_0001;
      flag_map  = 64'd0;
      adj       = adj_of(64'h8000_0000_0000_0001);
      tick();
      tick();
      check_vec("rst_revealed", revealed, 64'd0);
      check_vec("rst_busy", {63'd0, busy}, 64'd0);
      check_vec("rst_done", {63'd0, done}, 64'd0);
      check_vec("rst_hit", {63'd0, hit_mine}, 64'd0);
      check_vec("rst_win", {63'd0, win}, 64'd0);
      rst = 1'b0;
      tick();

      // 1: nonzero safe tile
      click(6'd9, lat, bok);
      check_vec("t1_lat", lat, 3);
      check_vec("t1_busy", {63'd0, bok}, 64'd1);
      check_vec("t1_revealed", revealed, 64'h200);
      check_vec("t1_hit", {63'd0, hit_mine}, 64'd0);
      check_vec("t1_win", {63'd0, win}, 64'd0);
      tick();
      check_vec("t1_done_pulse", {63'd0, done}, 64'd0);
      check_vec("t1_idle", {63'd0, busy}, 64'd0);

      // 2: mine click, then further clicks ignored
      click(6'd0, lat, bok);
      check_vec("t2_lat", lat, 1);
      check_vec("t2_revealed", revealed, 64'h201);
      check_vec("t2_hit", {63'd0, hit_mine}, 64'd1);
      tick();
      try_ignored("t2_after_hit", 6'd5);

      // 5: new_game with start drops the start
      new_game  = 1'b1;
      start     = 1'b1;
      sel_index = 6'd9;
      tick();
      new_game = 1'b0;
      start    = 1'b0;
      check_vec("t5_ng_revealed", revealed, 64'd0);
      check_vec("t5_ng_hit", {63'd0, hit_mine}, 64'd0);
      check_vec("t5_ng_busy", {63'd0, busy}, 64'd0);
      tick();
      check_vec("t5_ng_busy2", {63'd0, busy}, 64'd0);
      adj_valid = 1'b0;
      try_ignored("t5_noadj", 6'd9);
      adj_valid = 1'b1;
      flag_map  = 64'h200;
      try_ignored("t5_flagged", 6'd9);
      flag_map = 64'd0;
      click(6'd9, lat, bok);
      check_vec("t5_click_lat", lat, 3);
      tick();
      try_ignored("t5_revealed", 6'd9);

      // 3: full flood
      clear_game();
      mine_map = 64'd0;
      adj      = '0;
      click(6'd27, lat, bok);
      check_vec("t3_lat_le578", {63'd0, (lat <= 578)}, 64'd1);
      check_vec("t3_busy", {63'd0, bok}, 64'd1);
      check_vec("t3_revealed", revealed, {64{1'b1}});
      tick();
      check_vec("t3_win", {63'd0, win}, 64'd1);
      check_vec("t3_hit", {63'd0, hit_mine}, 64'd0);

      // 4: flagged column 4 blocks the flood
      clear_game();
      check_vec("t4_win_cleared", {63'd0, win}, 64'd0);
      flag_map = 64'h1010_1010_1010_1010;
      click(6'd0, lat, bok);
      check_vec("t4_lat_le578", {63'd0, (lat <= 578)}, 64'd1);
      check_vec("t4_revealed", revealed, 64'h0F0F_0F0F_0F0F_0F0F);
      tick();
      check_vec("t4_win", {63'd0, win}, 64'd0);

      // 6: reset mid-flood, then a normal click
      clear_game();
      flag_map  = 64'd0;
      sel_index = 6'd27;
      start     = 1'b1;
      tick();
      start = 1'b0;
      repeat (40) tick();
      check_vec("t6_midflood_busy", {63'd0, busy}, 64'd1);
      rst = 1'b1;
      tick();
      check_vec("t6_rst_revealed", revealed, 64'd0);
      check_vec("t6_rst_busy", {63'd0, busy}, 64'd0);
      check_vec("t6_rst_done", {63'd0, done}, 64'd0);
      rst      = 1'b0;
      mine_map = 64'h8000_0000_0000_0001;
      adj      = adj_of(64'h8000_0000_0000_0001);
      tick();
      click(6'd9, lat, bok);
      check_vec("t6_lat", lat, 3);
      check_vec("t6_revealed", revealed, 64'h200);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
